// File: rtl/gs_div_seq.sv
`default_nettype none
// gs_div_seq -- iterative Goldschmidt divider, IEEE-754 single precision, start/done handshake.
// Rev 1.0: one factor unit and two multipliers reused over ITERS cycles; special operands bypass the loop.
module gs_div_seq #(
  parameter int ITERS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] numerator,
  input  logic [31:0] denominator,
  output logic        busy,
  output logic        done,
  output logic [31:0] out_division,
  output logic        nan,
  output logic        pos_inf,
  output logic        neg_inf,
  output logic        pos_zero,
  output logic        neg_zero
);

  if (ITERS < 1 || ITERS > 8) begin : g_iters_range
    $error("gs_div_seq: ITERS must be in 1..8");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESCALE = 2'd1,
    ITER     = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [3:0]  LAST_ITER = 4'(ITERS - 1);
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;

  // Flag vector order: {nan, pos_inf, neg_inf, pos_zero, neg_zero}
  localparam logic [4:0] FLAG_NAN  = 5'b10000;
  localparam logic [4:0] FLAG_PINF = 5'b01000;
  localparam logic [4:0] FLAG_NINF = 5'b00100;
  localparam logic [4:0] FLAG_PZER = 5'b00010;
  localparam logic [4:0] FLAG_NZER = 5'b00001;

  // Single-precision multiply of normal operands, round-to-nearest-even, exponent modulo 2^8.
  function automatic logic [31:0] float_mult(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] prod;
    logic [7:0]  exp_r;
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic [23:0] mant_rnd;
    prod  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    exp_r = a[30:23] + b[30:23] - 8'd127;
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_r  = exp_r + 8'd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    mant_rnd = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
    if (mant_rnd[23]) begin
      exp_r = exp_r + 8'd1;
    end
    return {a[31] ^ b[31], exp_r, mant_rnd[22:0]};
  endfunction

  // Goldschmidt factor f = 2 - d for a positive d near 1 (exponent 126 or 127).
  function automatic logic [31:0] mult_factor(input logic [30:0] d);
    logic [30:0] d_fix;
    logic [30:0] f_fix;
    logic [7:0]  exp_r;
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic [23:0] mant_rnd;
    // Q1.30 fixed point; 2.0 wraps to zero so the subtraction is a plain negate.
    d_fix = (d[30:23] == 8'd127) ? {1'b1, d[22:0], 7'd0} : {1'b0, 1'b1, d[22:0], 6'd0};
    f_fix = 31'd0 - d_fix;
    if (f_fix[30]) begin
      exp_r  = 8'd127;
      mant   = f_fix[29:7];
      guard  = f_fix[6];
      sticky = |f_fix[5:0];
    end else begin
      exp_r  = 8'd126;
      mant   = f_fix[28:6];
      guard  = f_fix[5];
      sticky = |f_fix[4:0];
    end
    mant_rnd = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
    if (mant_rnd[23]) begin
      exp_r = exp_r + 8'd1;
    end
    return {1'b0, exp_r, mant_rnd[22:0]};
  endfunction

  state_t      state_q, state_d;
  logic [30:0] num_q, num_d;
  logic [30:0] den_q, den_d;
  logic        sign_q, sign_d;
  logic [31:0] d_q, d_d;
  logic [31:0] n_q, n_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] out_q, out_d;
  logic [4:0]  flags_q, flags_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        w_sign;
  logic        w_num_nan, w_num_inf, w_num_zero;
  logic        w_den_nan, w_den_inf, w_den_zero;
  logic        w_special;
  logic [31:0] w_special_out;
  logic [4:0]  w_special_flags;
  logic [31:0] w_f;
  logic [31:0] w_d_next;
  logic [31:0] w_n_next;

  always_comb begin
    w_sign     = numerator[31] ^ denominator[31];
    w_num_nan  = (&numerator[30:23]) & (|numerator[22:0]);
    w_num_inf  = (&numerator[30:23]) & ~(|numerator[22:0]);
    w_num_zero = ~(|numerator[30:0]);
    w_den_nan  = (&denominator[30:23]) & (|denominator[22:0]);
    w_den_inf  = (&denominator[30:23]) & ~(|denominator[22:0]);
    w_den_zero = ~(|denominator[30:0]);

    w_special       = 1'b1;
    w_special_out   = QNAN;
    w_special_flags = FLAG_NAN;
    if (w_num_nan | w_den_nan | (w_num_zero & w_den_zero) | (w_num_inf & w_den_inf)) begin
      w_special_out   = QNAN;
      w_special_flags = FLAG_NAN;
    end else if (w_num_zero | (~w_num_inf & w_den_inf)) begin
      w_special_out   = {w_sign, 31'd0};
      w_special_flags = w_sign ? FLAG_NZER : FLAG_PZER;
    end else if (w_num_inf | w_den_zero) begin
      w_special_out   = {w_sign, 8'hFF, 23'd0};
      w_special_flags = w_sign ? FLAG_NINF : FLAG_PINF;
    end else begin
      w_special = 1'b0;
    end
  end

  // Shared datapath: all three results come from the same pre-edge d_q and n_q.
  always_comb begin
    w_f      = mult_factor(d_q[30:0]);
    w_d_next = float_mult(w_f, d_q);
    w_n_next = float_mult(w_f, n_q);
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    sign_d  = sign_q;
    d_d     = d_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    flags_d = flags_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_d  = numerator[30:0];
          den_d  = denominator[30:0];
          sign_d = w_sign;
          if (w_special) begin
            out_d   = w_special_out;
            flags_d = w_special_flags;
            state_d = DONE;
          end else begin
            state_d = PRESCALE;
          end
        end
      end
      PRESCALE: begin
        // Divisor mantissa mapped into [0.5,1); the numerator absorbs the exponent shift.
        d_d     = {1'b0, 8'd126, den_q[22:0]};
        n_d     = {1'b0, num_q[30:23] + (8'd126 - den_q[30:23]), num_q[22:0]};
        cnt_d   = 4'd0;
        state_d = ITER;
      end
      ITER: begin
        d_d   = w_d_next;
        n_d   = w_n_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) begin
          out_d   = {sign_q, w_n_next[30:0]};
          flags_d = 5'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= 31'd0;
      den_q   <= 31'd0;
      sign_q  <= 1'b0;
      d_q     <= 32'd0;
      n_q     <= 32'd0;
      cnt_q   <= 4'd0;
      out_q   <= 32'd0;
      flags_q <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      sign_q  <= sign_d;
      d_q     <= d_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign out_division = out_q;
  assign nan          = flags_q[4];
  assign pos_inf      = flags_q[3];
  assign neg_inf      = flags_q[2];
  assign pos_zero     = flags_q[1];
  assign neg_zero     = flags_q[0];

endmodule
`default_nettype wire
